// File: rtl/mm44_seq_pkg.sv
// mm44_pkg: shared definitions for the mm44 array sequencer.
//   AW              address width of both SRAM ports
//   *_DEF           default timing parameters of mm44_seq
//   state_e         sequencer state encoding
package mm44_pkg;

   localparam int AW            = 10;
   localparam int RD_LAT_DEF    = 1;
   localparam int DRAIN_CYC_DEF = 7;   // 2*4-1 array flush cycles
   localparam int OUT_WORDS_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FEED  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_OUT   = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/mm44_seq_en_delay.sv
// en_delay: DEPTH-deep single-bit shift register for strobe alignment.
//   clk    rising-edge clock
//   rst    asynchronous active-high clear of every stage
//   flush  synchronous clear of every stage (wins over din)
//   din    strobe in
//   dout   strobe delayed by DEPTH cycles
module en_delay #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   generate
      if (DEPTH == 1) begin : g_one
         always_comb begin
            sr_d = flush ? 1'b0 : din;
         end
      end else begin : g_many
         always_comb begin
            sr_d = flush ? '0 : {sr_q[DEPTH-2:0], din};
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end

   assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/mm44_seq.sv
// mm44_seq: streams len operand words from sram_input into the systolic
// array, waits for the array to flush, then reads OUT_WORDS result words
// out of the array and writes them to sram_output.
//   clk, rst                    clock, async active-high reset
//   start, abort                operation request / cancel
//   base_in, len, base_out      operand base, operand count, result base
//   busy, done                  status, one-cycle completion pulse
//   input_en_ramin, wr_in,
//   adder_in                    sram_input chip select / write enable / address
//   input_en_sys, output_en_sys array operand-valid and result-read strobes
//   input_en_ramout, wr_out,
//   adder_out                   sram_output chip select / write enable / address
//
// state    | meaning
// IDLE     | waiting for start
// FEED     | one operand read per cycle, len cycles
// DRAIN    | array flush, DRAIN_CYC cycles, no reads
// OUT      | OUT_WORDS result reads then RD_LAT cycles for the last writes
// DONE     | single cycle, done pulse
module mm44_seq
   import mm44_pkg::*;
#(
   parameter int RD_LAT    = RD_LAT_DEF,
   parameter int DRAIN_CYC = DRAIN_CYC_DEF,
   parameter int OUT_WORDS = OUT_WORDS_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] base_in,
   input  logic [AW-1:0] len,
   input  logic [AW-1:0] base_out,
   output logic          busy,
   output logic          done,
   output logic          input_en_ramin,
   output logic          wr_in,
   output logic [AW-1:0] adder_in,
   output logic          input_en_sys,
   output logic          output_en_sys,
   output logic          input_en_ramout,
   output logic          wr_out,
   output logic [AW-1:0] adder_out
);

   localparam logic [AW-1:0] DRAIN_LD = AW'(DRAIN_CYC - 1);
   localparam logic [AW-1:0] OUT_LD   = AW'(OUT_WORDS + RD_LAT - 1);
   localparam logic [AW-1:0] RD_LAT_C = AW'(RD_LAT);
   localparam logic [AW-1:0] OW_C     = AW'(OUT_WORDS);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] ain_q, ain_d;
   logic [AW-1:0] aout_q, aout_d;
   logic [AW-1:0] bout_q, bout_d;
   logic          ramin_q, ramin_d;
   logic          osys_q, osys_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          sys_in;
   logic          wr_stb;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bout_d  = bout_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bout_d = base_out;
               if (len != '0) begin
                  state_d = ST_FEED;
                  cnt_d   = len - 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_FEED: begin
            if (cnt_q == '0) begin
               state_d = ST_DRAIN;
               cnt_d   = DRAIN_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = ST_OUT;
               cnt_d   = OUT_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_OUT: begin
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;

      // read address: load base on entry to FEED, step while staying in it
      ain_d = ain_q;
      if (state_d == ST_FEED) ain_d = (state_q == ST_FEED) ? ain_q + 1'b1 : base_in;

      // write k lands at OUT index RD_LAT+k; the edge before it has cnt_q = OUT_WORDS-k
      aout_d = aout_q;
      if (state_q == ST_OUT && !abort) begin
         if (cnt_q == OW_C)                        aout_d = bout_q;
         else if (cnt_q != '0 && cnt_q < OW_C)     aout_d = aout_q + 1'b1;
      end

      ramin_d = (state_d == ST_FEED);
      osys_d  = (state_d == ST_OUT) && (cnt_d >= RD_LAT_C);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ain_q   <= '0;
         aout_q  <= '0;
         bout_q  <= '0;
         ramin_q <= 1'b0;
         osys_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ain_q   <= ain_d;
         aout_q  <= aout_d;
         bout_q  <= bout_d;
         ramin_q <= ramin_d;
         osys_q  <= osys_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   en_delay #(.DEPTH(RD_LAT)) u_dly_sys (
      .clk   (clk),
      .rst   (rst),
      .flush (abort),
      .din   (ramin_q),
      .dout  (sys_in)
   );

   en_delay #(.DEPTH(RD_LAT)) u_dly_wr (
      .clk   (clk),
      .rst   (rst),
      .flush (abort),
      .din   (osys_q),
      .dout  (wr_stb)
   );

   assign busy            = busy_q;
   assign done            = done_q;
   assign input_en_ramin  = ramin_q;
   assign wr_in           = 1'b0;
   assign adder_in        = ain_q;
   assign input_en_sys    = sys_in;
   assign output_en_sys   = osys_q;
   assign input_en_ramout = wr_stb;
   assign wr_out          = wr_stb;
   assign adder_out       = aout_q;

endmodule
